cap_prop_monitor: RTL and testbench
===================================

# cap_prop_monitor

Parametrised, clocked property-check monitor for the capability formal and simulation benches. It accepts a stream of (base, len, addr) stimulus vectors together with the pass/fail results of up to NUM_PROPS external property-checker instances fed from the same vector. It pipelines and masks those results and keeps sticky per-property failure flags, saturating counters and a first-failure capture. It can optionally halt the stimulus stream on the first failure. It replaces the per-property combinational assertion wrappers with a single block that scales in width and property count.

## Interface
Parameters:
- ADDR_W, 32 — width of base/len/addr (32 or 64 supported).
- NUM_PROPS, 8 — number of property result channels (1..32).
- CNT_W, 16 — width of every counter.
- IDX_W, max(1, $clog2(NUM_PROPS)) — property index width, derived.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- in_valid  in  1  stimulus vector present.
- in_ready  out  1  monitor accepts vector this cycle.
- in_base / in_len / in_addr  in  ADDR_W each  stimulus vector (also wired to checker instances externally).
- in_prop_ok  in  NUM_PROPS  per-property result for the current in_* vector, bit i = property i holds.
- cfg_enable  in  NUM_PROPS  per-property check enable; disabled results are ignored.
- cfg_halt_on_fail  in  1  halt mode select.
- clear  in  1  synchronous clear of all monitor state.
- fail_sticky  out  NUM_PROPS  bit i set once property i has failed since reset/clear.
- fail_any  out  1  OR of fail_sticky.
- checked_count  out  CNT_W  vectors retired.
- fail_count  out  NUM_PROPS*CNT_W  per-property failure counts, property i at [i*CNT_W +: CNT_W].
- first_fail_valid  out  1  capture registers hold data.
- first_fail_prop  out  IDX_W  lowest failing property index of the first failing vector.
- first_fail_base / first_fail_len / first_fail_addr  out  ADDR_W each  captured vector.
- halted  out  1  stream stopped by halt mode.

## Operation
- Acceptance: a vector is accepted on a cycle where in_valid && in_ready. The block registers it, together with its fail mask (cfg_enable & ~in_prop_ok, sampled at acceptance), into stage S1 (s1_valid).
- Retire: on the next edge, an S1 entry with s1_valid updates state:
  - checked_count += 1.
  - For each set mask bit i: fail_count[i] += 1 and fail_sticky[i] <= 1.
  - If the mask is non-zero and first_fail_valid == 0: capture the vector and the lowest set bit index, and set first_fail_valid.
  - If the mask is non-zero and cfg_halt_on_fail == 1: set halted.
- Counters saturate at all-ones and never wrap.
- in_ready = !RST && !halted && !(cfg_halt_on_fail && s1_valid && |s1_mask).
  - No vector following a failing one is accepted in halt mode.
  - in_ready is combinational from state and cfg only, never from in_valid.
- halted clears only on clear or reset. Changing cfg_halt_on_fail while halted has no effect until clear.
- clear (registered effect on the next edge):
  - Zeroes counters, fail_sticky, first_fail_*, halted.
  - Discards the current S1 entry without retiring it.
  - A vector accepted in the clear cycle is loaded into S1 normally and counted after the clear.
- cfg_enable changes apply to vectors accepted after the change; entries already in S1 keep their sampled mask.
- Reset (RST high): all outputs 0, including in_ready, and s1_valid = 0. Mid-stream reset drops the S1 entry. After RST falls, in_ready = 1 from the first cycle.

## Timing
- Acceptance at edge T loads S1. Retire at edge T+1, so outputs reflect the vector from cycle T+1: latency 2 edges from the acceptance cycle.
- Throughput: one vector per cycle while no halt is pending.
- Halt mode: in_ready drops in the cycle after a failing acceptance (S1 holds the failure). It stays low until clear is applied and has taken effect.
- Simultaneous clear and S1 retire: clear wins and nothing from S1 is counted.
- Simultaneous failures on several properties: all counters and sticky bits update together; first_fail_prop takes the lowest index.

## Test plan
- Reset release with in_valid=1 and all in_prop_ok=1 for 10 cycles: in_ready=1 every cycle, checked_count=10 two edges after the last acceptance, fail_any=0, all fail_count=0.
- Single failure, NUM_PROPS=8, halt off: vector (base=0x1000, len=0x40, addr=0x1010) with prop_ok=0xF5 (bits 1 and 3 fail), then 3 passing vectors.
  - Required: fail_sticky=0x0A; fail_count[1]=fail_count[3]=1; first_fail_prop=1 with base/len/addr captured; a later failure on bit 0 does not overwrite the capture.
- Halt mode: third vector fails bit 5.
  - Required: in_ready=0 from the next cycle; halted=1; checked_count=3 and stays 3 while in_valid is held high for 20 cycles.
  - Apply clear: in_ready=1 the cycle after, all state zero.
- Masking: cfg_enable=0xFE and prop_ok=0xFE on every vector: no failures recorded. Change to cfg_enable=0xFF: the next accepted vector sets fail_sticky bit 0.
- Saturation with CNT_W=4: 20 failing vectors on bit 2. Required: fail_count[2]=15 and checked_count=15, both held at 15.
- Clear coincident with a failing S1 entry, plus RST asserted mid-stream: the failing vector is not counted; after reset all outputs are 0, then in_ready=1.

Source files
------------

// File: rtl/cap_prop_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : cap_prop_monitor
//  Purpose  : Pipelined property-result monitor with sticky flags, saturating
//             counters, first-failure capture and optional halt-on-fail.
//  Revision : 1.0 - initial release
// ============================================================================
module cap_prop_monitor #(
    parameter int ADDR_W    = 32,
    parameter int NUM_PROPS = 8,
    parameter int CNT_W     = 16,
    parameter int IDX_W     = (NUM_PROPS > 1) ? $clog2(NUM_PROPS) : 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_base,
    input  logic [ADDR_W-1:0]          in_len,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic [NUM_PROPS-1:0]       in_prop_ok,
    input  logic [NUM_PROPS-1:0]       cfg_enable,
    input  logic                       cfg_halt_on_fail,
    input  logic                       clear,
    output logic [NUM_PROPS-1:0]       fail_sticky,
    output logic                       fail_any,
    output logic [CNT_W-1:0]           checked_count,
    output logic [NUM_PROPS*CNT_W-1:0] fail_count,
    output logic                       first_fail_valid,
    output logic [IDX_W-1:0]           first_fail_prop,
    output logic [ADDR_W-1:0]          first_fail_base,
    output logic [ADDR_W-1:0]          first_fail_len,
    output logic [ADDR_W-1:0]          first_fail_addr,
    output logic                       halted
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic                 r_s1_valid;
    logic [NUM_PROPS-1:0] r_s1_mask;
    logic [ADDR_W-1:0]    r_s1_base, r_s1_len, r_s1_addr;
    logic [NUM_PROPS-1:0] r_fail_sticky;
    logic [CNT_W-1:0]     r_checked_count;
    logic                 r_ff_valid;
    logic [IDX_W-1:0]     r_ff_prop;
    logic [ADDR_W-1:0]    r_ff_base, r_ff_len, r_ff_addr;
    logic                 r_halted;

    logic                 w_accept;
    logic                 w_retire;
    logic                 w_s1_fail;
    logic [IDX_W-1:0]     w_low_idx;

    // Halt back-pressure looks only at the already-registered S1 failure.
    assign in_ready  = !RST && !r_halted && !(cfg_halt_on_fail && w_s1_fail);
    assign w_accept  = in_valid && in_ready;
    assign w_s1_fail = r_s1_valid && (|r_s1_mask);
    assign w_retire  = r_s1_valid && !clear;

    always_comb begin
        w_low_idx = '0;
        for (int i = NUM_PROPS - 1; i >= 0; i--) begin
            if (r_s1_mask[i]) w_low_idx = IDX_W'(i);
        end
    end

    // S1 loads regardless of clear so a vector accepted alongside clear survives.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_s1_valid <= 1'b0;
            r_s1_mask  <= '0;
            r_s1_base  <= '0;
            r_s1_len   <= '0;
            r_s1_addr  <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_mask <= cfg_enable & ~in_prop_ok;
                r_s1_base <= in_base;
                r_s1_len  <= in_len;
                r_s1_addr <= in_addr;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_fail_sticky   <= '0;
            r_checked_count <= '0;
            r_ff_valid      <= 1'b0;
            r_ff_prop       <= '0;
            r_ff_base       <= '0;
            r_ff_len        <= '0;
            r_ff_addr       <= '0;
            r_halted        <= 1'b0;
        end else if (clear) begin
            r_fail_sticky   <= '0;
            r_checked_count <= '0;
            r_ff_valid      <= 1'b0;
            r_ff_prop       <= '0;
            r_ff_base       <= '0;
            r_ff_len        <= '0;
            r_ff_addr       <= '0;
            r_halted        <= 1'b0;
        end else if (w_retire) begin
            r_fail_sticky <= r_fail_sticky | r_s1_mask;
            if (r_checked_count != c_cnt_max) r_checked_count <= r_checked_count + 1'b1;
            if (w_s1_fail && !r_ff_valid) begin
                r_ff_valid <= 1'b1;
                r_ff_prop  <= w_low_idx;
                r_ff_base  <= r_s1_base;
                r_ff_len   <= r_s1_len;
                r_ff_addr  <= r_s1_addr;
            end
            if (w_s1_fail && cfg_halt_on_fail) r_halted <= 1'b1;
        end
    end

    generate
        for (genvar g = 0; g < NUM_PROPS; g++) begin : g_fail_cnt
            logic [CNT_W-1:0] r_cnt;
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_cnt <= '0;
                end else if (clear) begin
                    r_cnt <= '0;
                end else if (w_retire && r_s1_mask[g] && (r_cnt != c_cnt_max)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            assign fail_count[g*CNT_W +: CNT_W] = r_cnt;
        end
    endgenerate

    assign fail_sticky      = r_fail_sticky;
    assign fail_any         = |r_fail_sticky;
    assign checked_count    = r_checked_count;
    assign first_fail_valid = r_ff_valid;
    assign first_fail_prop  = r_ff_prop;
    assign first_fail_base  = r_ff_base;
    assign first_fail_len   = r_ff_len;
    assign first_fail_addr  = r_ff_addr;
    assign halted           = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_cap_prop_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cap_prop_monitor
//  Purpose  : Self-checking bench; two monitor instances (16-bit and 4-bit
//             counters) driven in lockstep against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cap_prop_monitor;

    logic        clk = 1'b0;
    logic        rst, in_valid, cfg_halt, clr;
    logic [31:0] in_base, in_len, in_addr;
    logic [7:0]  prop_ok, cfg_en;

    logic         a_rdy, a_any, a_fv, a_h, b_rdy, b_any, b_fv, b_h;
    logic [7:0]   a_st, b_st;
    logic [15:0]  a_cc;
    logic [3:0]   b_cc;
    logic [127:0] a_fc;
    logic [31:0]  b_fc;
    logic [2:0]   a_fp, b_fp;
    logic [31:0]  a_fb, a_fl, a_fa, b_fb, b_fl, b_fa;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cap_prop_monitor #(.ADDR_W(32), .NUM_PROPS(8), .CNT_W(16)) u_dut_a (
        .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(a_rdy),
        .in_base(in_base), .in_len(in_len), .in_addr(in_addr),
        .in_prop_ok(prop_ok), .cfg_enable(cfg_en), .cfg_halt_on_fail(cfg_halt),
        .clear(clr), .fail_sticky(a_st), .fail_any(a_any), .checked_count(a_cc),
        .fail_count(a_fc), .first_fail_valid(a_fv), .first_fail_prop(a_fp),
        .first_fail_base(a_fb), .first_fail_len(a_fl), .first_fail_addr(a_fa),
        .halted(a_h)
    );

    cap_prop_monitor #(.ADDR_W(32), .NUM_PROPS(8), .CNT_W(4)) u_dut_b (
        .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(b_rdy),
        .in_base(in_base), .in_len(in_len), .in_addr(in_addr),
        .in_prop_ok(prop_ok), .cfg_enable(cfg_en), .cfg_halt_on_fail(cfg_halt),
        .clear(clr), .fail_sticky(b_st), .fail_any(b_any), .checked_count(b_cc),
        .fail_count(b_fc), .first_fail_valid(b_fv), .first_fail_prop(b_fp),
        .first_fail_base(b_fb), .first_fail_len(b_fl), .first_fail_addr(b_fa),
        .halted(b_h)
    );

    // Reference model: raw event counts since the last clear; saturation
    // is applied only when comparing against a given counter width.
    bit          m_pv, m_fv, m_h;
    logic [7:0]  m_pm, m_st;
    logic [31:0] m_pb, m_pl, m_pa, m_fb, m_fl, m_fa;
    int          m_chk, m_fp;
    int          m_fc[8];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint sat(input int raw, input int w);
        longint mx = (longint'(1) << w) - 1;
        return (longint'(raw) > mx) ? mx : longint'(raw);
    endfunction

    function automatic bit model_ready();
        return !rst && !m_h && !(cfg_halt && m_pv && (m_pm != 8'h00));
    endfunction

    task automatic model_clear_stats();
        m_st = '0; m_chk = 0; m_fv = 0; m_fp = 0; m_h = 0;
        m_fb = '0; m_fl = '0; m_fa = '0;
        foreach (m_fc[i]) m_fc[i] = 0;
    endtask

    task automatic model_reset();
        model_clear_stats();
        m_pv = 0; m_pm = '0;
    endtask

    task automatic model_edge(input bit acc);
        if (clr) begin
            model_clear_stats();
        end else if (m_pv) begin
            m_chk++;
            m_st |= m_pm;
            for (int i = 0; i < 8; i++) if (m_pm[i]) m_fc[i]++;
            if (m_pm != 0 && !m_fv) begin
                m_fv = 1; m_fb = m_pb; m_fl = m_pl; m_fa = m_pa;
                for (int i = 7; i >= 0; i--) if (m_pm[i]) m_fp = i;
            end
            if (m_pm != 0 && cfg_halt) m_h = 1;
        end
        m_pv = acc;
        if (acc) begin
            m_pm = cfg_en & ~prop_ok; m_pb = in_base; m_pl = in_len; m_pa = in_addr;
        end
    endtask

    task automatic check_one(input string n, input int w, input logic rdy, input logic [7:0] st,
                             input logic an, input logic [15:0] cc, input logic [127:0] fc,
                             input logic fv, input logic [2:0] fp, input logic [31:0] fb,
                             input logic [31:0] fl, input logic [31:0] fa, input logic h);
        logic [127:0] msk = (128'(1) << w) - 128'(1);
        check({n, ".in_ready"}, 64'(rdy), 64'(model_ready()));
        check({n, ".fail_sticky"}, 64'(st), 64'(m_st));
        check({n, ".fail_any"}, 64'(an), 64'(|m_st));
        check({n, ".checked_count"}, 64'(cc), 64'(sat(m_chk, w)));
        for (int i = 0; i < 8; i++)
            check($sformatf("%s.fail_count[%0d]", n, i), 64'((fc >> (i * w)) & msk), 64'(sat(m_fc[i], w)));
        check({n, ".first_fail_valid"}, 64'(fv), 64'(m_fv));
        check({n, ".first_fail_prop"}, 64'(fp), 64'(m_fp));
        check({n, ".first_fail_base"}, 64'(fb), 64'(m_fb));
        check({n, ".first_fail_len"}, 64'(fl), 64'(m_fl));
        check({n, ".first_fail_addr"}, 64'(fa), 64'(m_fa));
        check({n, ".halted"}, 64'(h), 64'(m_h));
    endtask

    task automatic check_all();
        check_one("A", 16, a_rdy, a_st, a_any, a_cc, a_fc, a_fv, a_fp, a_fb, a_fl, a_fa, a_h);
        check_one("B", 4, b_rdy, b_st, b_any, 16'(b_cc), 128'(b_fc), b_fv, b_fp, b_fb, b_fl, b_fa, b_h);
    endtask

    task automatic cycle(input bit v, input logic [31:0] b, input logic [31:0] l, input logic [31:0] a,
                         input logic [7:0] ok, input logic [7:0] en, input bit h, input bit c);
        bit acc;
        @(negedge clk);
        in_valid = v; in_base = b; in_len = l; in_addr = a;
        prop_ok = ok; cfg_en = en; cfg_halt = h; clr = c;
        #1;
        check("A.in_ready_pre", 64'(a_rdy), 64'(model_ready()));
        acc = v && model_ready();
        @(posedge clk);
        model_edge(acc);
        #1;
        check_all();
    endtask

    task automatic idle(input int n, input logic [7:0] en, input bit h);
        repeat (n) cycle(0, 32'h0, 32'h0, 32'h0, 8'hFF, en, h, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; in_valid = 0; clr = 0;
        #1;
        model_reset();
        check_all();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        rst = 1; in_valid = 0; cfg_halt = 0; clr = 0;
        in_base = '0; in_len = '0; in_addr = '0; prop_ok = '1; cfg_en = '1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 0;

        // Ten passing vectors straight out of reset
        for (int i = 0; i < 10; i++) cycle(1, 32'(i), 32'h10, 32'(i + 4), 8'hFF, 8'hFF, 0, 0);
        idle(2, 8'hFF, 0);
        check("plan.checked10", 64'(a_cc), 64'd10);
        check("plan.no_fail", 64'(a_any), 64'd0);

        // Single multi-bit failure, capture must not be overwritten later
        cycle(0, 0, 0, 0, 8'hFF, 8'hFF, 0, 1);
        cycle(1, 32'h1000, 32'h40, 32'h1010, 8'hF5, 8'hFF, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 32'h2000, 32'h10, 32'h2004, 8'hFF, 8'hFF, 0, 0);
        idle(1, 8'hFF, 0);
        check("plan.sticky_0A", 64'(a_st), 64'h0A);
        check("plan.fc1", 64'(a_fc[16 +: 16]), 64'd1);
        check("plan.fc3", 64'(a_fc[48 +: 16]), 64'd1);
        check("plan.ff_prop", 64'(a_fp), 64'd1);
        check("plan.ff_base", 64'(a_fb), 64'h1000);
        cycle(1, 32'h3000, 32'h8, 32'h3000, 8'hFE, 8'hFF, 0, 0);
        idle(2, 8'hFF, 0);
        check("plan.ff_kept", 64'(a_fp), 64'd1);
        check("plan.ff_addr_kept", 64'(a_fa), 64'h1010);

        // Halt mode: third vector fails bit 5, stream held for 20 cycles
        cycle(0, 0, 0, 0, 8'hFF, 8'hFF, 1, 1);
        cycle(1, 32'h10, 32'h10, 32'h10, 8'hFF, 8'hFF, 1, 0);
        cycle(1, 32'h20, 32'h10, 32'h20, 8'hFF, 8'hFF, 1, 0);
        cycle(1, 32'h30, 32'h10, 32'h30, 8'hDF, 8'hFF, 1, 0);
        for (int i = 0; i < 20; i++) cycle(1, 32'h40, 32'h10, 32'h40, 8'hFF, 8'hFF, 1, 0);
        check("plan.halted", 64'(a_h), 64'd1);
        check("plan.halt_ready", 64'(a_rdy), 64'd0);
        check("plan.halt_count3", 64'(a_cc), 64'd3);
        cycle(0, 0, 0, 0, 8'hFF, 8'hFF, 0, 1);
        check("plan.clear_ready", 64'(a_rdy), 64'd1);
        check("plan.clear_count", 64'(a_cc), 64'd0);

        // Masking and enable change
        for (int i = 0; i < 5; i++) cycle(1, 32'(i), 32'h4, 32'(i), 8'hFE, 8'hFE, 0, 0);
        cycle(1, 32'h55, 32'h4, 32'h55, 8'hFE, 8'hFF, 0, 0);
        idle(2, 8'hFF, 0);
        check("plan.mask_sticky", 64'(a_st), 64'h01);

        // Saturation on the 4-bit instance
        cycle(0, 0, 0, 0, 8'hFF, 8'hFF, 0, 1);
        for (int i = 0; i < 20; i++) cycle(1, 32'(i), 32'h8, 32'(i), 8'hFB, 8'hFF, 0, 0);
        idle(2, 8'hFF, 0);
        check("plan.sat_fc2", 64'(b_fc[8 +: 4]), 64'd15);
        check("plan.sat_cc", 64'(b_cc), 64'd15);
        check("plan.wide_cc", 64'(a_cc), 64'd20);

        // Clear coincident with failing S1, then mid-stream reset
        cycle(0, 0, 0, 0, 8'hFF, 8'hFF, 0, 1);
        cycle(1, 32'h77, 32'h7, 32'h77, 8'hEF, 8'hFF, 0, 0);
        cycle(0, 0, 0, 0, 8'hFF, 8'hFF, 0, 1);
        idle(1, 8'hFF, 0);
        check("plan.clr_drop_cc", 64'(a_cc), 64'd0);
        check("plan.clr_drop_any", 64'(a_any), 64'd0);
        cycle(1, 32'h88, 32'h8, 32'h88, 8'h7F, 8'hFF, 0, 0);
        cycle(1, 32'h99, 32'h8, 32'h99, 8'hBF, 8'hFF, 0, 0);
        do_reset();
        cycle(1, 32'hAA, 32'h8, 32'hAA, 8'hFF, 8'hFF, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [7:0] ok = 8'hFF;
            for (int i = 0; i < 8; i++) if ($urandom_range(0, 15) == 0) ok[i] = 1'b0;
            if ($urandom_range(0, 199) == 0) do_reset();
            cycle($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom, ok,
                  ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 29) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
